multicycle_core: RTL and testbench

- Parametrised multi-cycle execution core: FETCH -> DECODE -> EXECUTE -> WRITEBACK.
- Generalises the first-generation control unit in three ways:
  - NUM_REGS registers of DATA_W bits instead of two fixed 32-bit registers.
  - Full 8-opcode ALU with immediate mode and zero/carry flags.
  - valid/ready instruction handshake instead of sampling switches.
- Sits between the board I/O wrapper (switches/keys/hex) and future instruction-memory logic. Debug read port feeds the hex displays.

---
 rtl/multicycle_core_if.sv | 26 ++
 rtl/multicycle_core.sv | 141 ++++++++++++++
 tb/tb_multicycle_core.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_core_if.sv
// Instruction handshake bundle between an instruction source and multicycle_core.
//   instr_valid : source -> core, instr_data holds an instruction
//   instr_data  : source -> core, {mode, opcode[2:0], regA, regB}
//   instr_ready : core -> source, core is in FETCH and will take the instruction
// master modport: instruction source. slave modport: the core.
interface multicycle_core_if #(
  parameter int unsigned REG_AW = 2
);
  localparam int unsigned INSTR_W = 4 + 2 * REG_AW;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic               instr_ready;

  modport master (
    output instr_valid,
    output instr_data,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_data,
    output instr_ready
  );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle execution core: FETCH -> DECODE -> EXEC -> WB, one instruction per four cycles.
// Ports:
//   clock_pulse : clock, all state changes on posedge
//   resetn      : asynchronous active-low reset
//   bus         : instruction handshake (slave side of multicycle_core_if)
//   dbg_sel     : register index for the debug read port
//   dbg_data    : combinational read of R[dbg_sel]
//   state       : FETCH=00, DECODE=01, EXEC=10, WB=11
//   flag_z      : last ALU result was zero
//   flag_c      : carry/borrow of the last ADD/SUB/INC/DEC, cleared by AND/OR/MOV
//   retire      : one-cycle pulse in the FETCH cycle following a writeback
module multicycle_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 2
) (
  input  logic              clock_pulse,
  input  logic              resetn,
  multicycle_core_if.slave  bus,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [1:0]        state,
  output logic              flag_z,
  output logic              flag_c,
  output logic              retire
);

  localparam int unsigned NUM_REGS = 2 ** REG_AW;
  localparam int unsigned INSTR_W  = 4 + 2 * REG_AW;
  localparam logic [DATA_W:0] One  = (DATA_W + 1)'(1);

  typedef enum logic [1:0] {
    StFetch  = 2'b00,
    StDecode = 2'b01,
    StExec   = 2'b10,
    StWb     = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    OpNop = 3'b000,
    OpAdd = 3'b001,
    OpSub = 3'b010,
    OpInc = 3'b011,
    OpDec = 3'b100,
    OpAnd = 3'b101,
    OpOr  = 3'b110,
    OpMov = 3'b111
  } op_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   opa_q, opb_q;
  logic [DATA_W:0]     res_q;  // bit DATA_W carries carry/borrow
  logic [DATA_W:0]     alu_res;
  logic                flag_z_q, flag_c_q, retire_q;

  // Instruction fields, decoded from the latched IR.
  logic              mode;
  op_e               opcode;
  logic [REG_AW-1:0] reg_a, reg_b;

  assign mode   = ir_q[INSTR_W-1];
  assign opcode = op_e'(ir_q[INSTR_W-2 -: 3]);
  assign reg_a  = ir_q[2*REG_AW-1 -: REG_AW];
  assign reg_b  = ir_q[REG_AW-1:0];

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (bus.instr_valid) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec:   state_d = StWb;
      StWb:     state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // ALU: all results are DATA_W+1 bits wide. Subtraction in DATA_W+1 bits leaves the borrow in
  // the top bit; logic ops and MOV zero it so the carry flag clears uniformly.
  always_comb begin
    alu_res = '0;
    unique case (opcode)
      OpNop: alu_res = '0;
      OpAdd: alu_res = {1'b0, opa_q} + {1'b0, opb_q};
      OpSub: alu_res = {1'b0, opa_q} - {1'b0, opb_q};
      OpInc: alu_res = {1'b0, opa_q} + One;
      OpDec: alu_res = {1'b0, opa_q} - One;
      OpAnd: alu_res = {1'b0, opa_q & opb_q};
      OpOr:  alu_res = {1'b0, opa_q | opb_q};
      OpMov: alu_res = {1'b0, opb_q};
      default: alu_res = '0;
    endcase
  end

  // State register plus datapath. Reset clears everything, so an in-flight instruction is lost.
  always_ff @(posedge clock_pulse or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StFetch;
      regs_q   <= '{default: '0};
      ir_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      retire_q <= (state_q == StWb);
      unique case (state_q)
        StFetch: begin
          if (bus.instr_valid) ir_q <= bus.instr_data;
        end
        StDecode: begin
          opa_q <= regs_q[reg_a];
          opb_q <= mode ? DATA_W'(reg_b) : regs_q[reg_b];
        end
        StExec: begin
          res_q <= alu_res;
        end
        StWb: begin
          if (opcode != OpNop) begin
            regs_q[reg_a] <= res_q[DATA_W-1:0];
            flag_z_q      <= (res_q[DATA_W-1:0] == '0);
            flag_c_q      <= res_q[DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_ready = (state_q == StFetch);
  assign dbg_data        = regs_q[dbg_sel];
  assign state           = state_q;
  assign flag_z          = flag_z_q;
  assign flag_c          = flag_c_q;
  assign retire          = retire_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core (DATA_W=32, REG_AW=2): directed table, handshake and
// reset corner cases, and random instructions against an arithmetic reference model.
module tb_multicycle_core;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 2;

  logic          clock_pulse;
  logic          resetn;
  logic [AW-1:0] dbg_sel;
  logic [DW-1:0] dbg_data;
  logic [1:0]    state;
  logic          flag_z, flag_c, retire;

  int checks   = 0;
  int failures = 0;

  multicycle_core_if #(.REG_AW(AW)) bus ();

  multicycle_core #(
    .DATA_W(DW),
    .REG_AW(AW)
  ) dut (
    .clock_pulse(clock_pulse),
    .resetn     (resetn),
    .bus        (bus),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .state      (state),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .retire     (retire)
  );

  initial clock_pulse = 1'b0;
  always #10 clock_pulse = ~clock_pulse;

  // Reference model: architectural registers and flags.
  logic [31:0] m_regs [4];
  logic        m_z, m_c;

  task automatic model_reset();
    for (int r = 0; r < 4; r++) m_regs[r] = '0;
    m_z = 1'b0;
    m_c = 1'b0;
  endtask

  task automatic model_exec(input logic [7:0] instr);
    int unsigned op, ra, rb;
    longint unsigned a, b, full;
    logic carry;
    op = instr[6:4];
    ra = instr[3:2];
    rb = instr[1:0];
    a  = m_regs[ra];
    b  = instr[7] ? longint'(rb) : longint'(m_regs[rb]);
    carry = 1'b0;
    full  = 0;
    case (op)
      0: return;
      1: begin full = a + b; carry = (full > 64'hFFFF_FFFF); end
      2: begin full = a - b; carry = (a < b); end
      3: begin full = a + 1; carry = (full > 64'hFFFF_FFFF); end
      4: begin full = a - 1; carry = (a == 0); end
      5: full = a & b;
      6: full = a | b;
      default: full = b;
    endcase
    m_regs[ra] = full[31:0];
    m_z = (full[31:0] == 32'd0);
    m_c = carry;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      check($sformatf("%s R%0d", tag, r), dbg_data, m_regs[r]);
    end
    check({tag, " flag_z"}, 32'(flag_z), 32'(m_z));
    check({tag, " flag_c"}, 32'(flag_c), 32'(m_c));
  endtask

  // Full instruction: handshake, walk the states, commit, compare with model, check retire width.
  task automatic run_instr(input logic [7:0] instr, input string tag);
    @(negedge clock_pulse);
    if (bus.instr_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s ready: got %b expected 1", tag, bus.instr_ready);
      return;
    end
    bus.instr_valid = 1'b1;
    bus.instr_data  = instr;
    @(posedge clock_pulse); #1;
    bus.instr_valid = 1'b0;
    check({tag, " st decode"}, 32'(state), 32'd1);
    @(posedge clock_pulse); #1;
    check({tag, " st exec"}, 32'(state), 32'd2);
    @(posedge clock_pulse); #1;
    check({tag, " st wb"}, 32'(state), 32'd3);
    @(posedge clock_pulse); #1;
    check({tag, " st fetch"}, 32'(state), 32'd0);
    check({tag, " retire"}, 32'(retire), 32'd1);
    model_exec(instr);
    check_model(tag);
    @(posedge clock_pulse); #1;
    check({tag, " retire off"}, 32'(retire), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  instr;
    int unsigned reg_idx;
    logic [31:0] val;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Hand-derived expectations, applied in order from reset.
    vecs.push_back('{8'hF6, 1, 32'h0000_0002, 1'b0, 1'b0});  // MOV R1,#2
    vecs.push_back('{8'h40, 0, 32'hFFFF_FFFF, 1'b0, 1'b1});  // DEC R0 (0 -> all ones)
    vecs.push_back('{8'h91, 0, 32'h0000_0000, 1'b1, 1'b1});  // ADD R0,#1 wraps
    vecs.push_back('{8'hFB, 2, 32'h0000_0003, 1'b0, 1'b0});  // MOV R2,#3
    vecs.push_back('{8'hFF, 3, 32'h0000_0003, 1'b0, 1'b0});  // MOV R3,#3
    vecs.push_back('{8'h9E, 3, 32'h0000_0005, 1'b0, 1'b0});  // ADD R3,#2
    vecs.push_back('{8'h2B, 2, 32'hFFFF_FFFE, 1'b0, 1'b1});  // SUB R2,R3 borrow
    vecs.push_back('{8'h2F, 3, 32'h0000_0000, 1'b1, 1'b0});  // SUB R3,R3
    vecs.push_back('{8'h00, 3, 32'h0000_0000, 1'b1, 1'b0});  // NOP keeps flags
    vecs.push_back('{8'h15, 1, 32'h0000_0004, 1'b0, 1'b0});  // ADD R1,R1 doubles
    vecs.push_back('{8'h96, 1, 32'h0000_0006, 1'b0, 1'b0});  // ADD R1,#2
    vecs.push_back('{8'hD7, 1, 32'h0000_0002, 1'b0, 1'b0});  // AND R1,#3
    vecs.push_back('{8'hE5, 1, 32'h0000_0003, 1'b0, 1'b0});  // OR R1,#1
    vecs.push_back('{8'h30, 0, 32'h0000_0001, 1'b0, 1'b0});  // INC R0
    vecs.push_back('{8'h79, 2, 32'h0000_0003, 1'b0, 1'b0});  // MOV R2,R1

    resetn          = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    dbg_sel         = '0;
    model_reset();
    #25;
    check("reset state", 32'(state), 32'd0);
    check("reset ready", 32'(bus.instr_ready), 32'd1);
    check("reset retire", 32'(retire), 32'd0);
    check_model("reset");
    @(negedge clock_pulse);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].instr, $sformatf("vec%0d", i));
      dbg_sel = 2'(vecs[i].reg_idx);
      #1;
      check($sformatf("vec%0d value", i), dbg_data, vecs[i].val);
      check($sformatf("vec%0d z", i), 32'(flag_z), 32'(vecs[i].z));
      check($sformatf("vec%0d c", i), 32'(flag_c), 32'(vecs[i].c));
    end

    // Stall: no valid, core stays in FETCH.
    for (int k = 0; k < 5; k++) begin
      @(posedge clock_pulse); #1;
      check("stall state", 32'(state), 32'd0);
      check("stall ready", 32'(bus.instr_ready), 32'd1);
    end

    // valid raised during EXEC/WB with a different instruction must be ignored.
    @(negedge clock_pulse);
    bus.instr_valid = 1'b1;
    bus.instr_data  = 8'h34;  // INC R1
    @(posedge clock_pulse); #1;
    bus.instr_valid = 1'b0;
    @(posedge clock_pulse); #1;
    check("ign st exec", 32'(state), 32'd2);
    check("ign ready", 32'(bus.instr_ready), 32'd0);
    bus.instr_valid = 1'b1;
    bus.instr_data  = 8'hF3;  // MOV R0,#3 - must not land in IR
    @(posedge clock_pulse); #1;
    check("ign st wb", 32'(state), 32'd3);
    bus.instr_valid = 1'b0;
    @(posedge clock_pulse); #1;
    check("ign retire", 32'(retire), 32'd1);
    model_exec(8'h34);
    check_model("ign");
    @(posedge clock_pulse); #1;
    check("ign st idle", 32'(state), 32'd0);

    // Random instructions against the model.
    for (int k = 0; k < 60; k++) begin
      run_instr(8'($urandom_range(0, 255)), $sformatf("rnd%0d", k));
    end

    // Make R1 nonzero, then reset during EXEC of INC R1.
    run_instr(8'hF7, "pre-rst");  // MOV R1,#3
    @(negedge clock_pulse);
    bus.instr_valid = 1'b1;
    bus.instr_data  = 8'h34;
    @(posedge clock_pulse); #1;
    bus.instr_valid = 1'b0;
    @(posedge clock_pulse); #1;
    check("mid st exec", 32'(state), 32'd2);
    resetn = 1'b0;
    #1;
    model_reset();
    check("mid rst state", 32'(state), 32'd0);
    check("mid rst retire", 32'(retire), 32'd0);
    check("mid rst ready", 32'(bus.instr_ready), 32'd1);
    check_model("mid rst");
    @(posedge clock_pulse); #1;
    check("mid rst hold", 32'(state), 32'd0);
    @(negedge clock_pulse);
    resetn = 1'b1;
    run_instr(8'hF6, "post-rst");  // MOV R1,#2
    run_instr(8'h35, "post-rst2"); // INC R1

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound in case something stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
